// File: rtl/cpu_defs.sv
// Shared definitions for the 8-bit core: ALU opcodes, instruction opcodes,
// sequencer state encodings and instruction-register field positions.
// Ports: none (package).
package cpu_defs;

  // ALU opcodes, identical to the datapath's encoding
  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_XOR = 3'd4;
  localparam logic [2:0] ALU_NOT = 3'd5;
  localparam logic [2:0] ALU_SHL = 3'd6;
  localparam logic [2:0] ALU_SHR = 3'd7;

  // Instruction opcodes (IR[15:12])
  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_XOR  = 4'h4;
  localparam logic [3:0] OP_NOT  = 4'h5;
  localparam logic [3:0] OP_SHL  = 4'h6;
  localparam logic [3:0] OP_SHR  = 4'h7;
  localparam logic [3:0] OP_LDI  = 4'h8;
  localparam logic [3:0] OP_ADDI = 4'h9;
  localparam logic [3:0] OP_LD   = 4'hA;
  localparam logic [3:0] OP_ST   = 4'hB;
  localparam logic [3:0] OP_JMP  = 4'hC;
  localparam logic [3:0] OP_BZ   = 4'hD;
  localparam logic [3:0] OP_BC   = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEMWB  = 3'd3,
    HALT   = 3'd4
  } state_t;

  // Instruction register field positions
  localparam int IR_OP_HI  = 15;
  localparam int IR_OP_LO  = 12;
  localparam int IR_RD_HI  = 11;
  localparam int IR_RD_LO  = 8;
  localparam int IR_RA_HI  = 7;
  localparam int IR_RA_LO  = 4;
  localparam int IR_RB_HI  = 3;
  localparam int IR_RB_LO  = 0;
  localparam int IR_IMM_HI = 7;
  localparam int IR_IMM_LO = 0;

  // Register-register instruction opcode -> ALU function
  function automatic logic [2:0] alu_of_op(input logic [3:0] op);
    case (op)
      OP_ADD:  return ALU_ADD;
      OP_SUB:  return ALU_SUB;
      OP_AND:  return ALU_AND;
      OP_OR:   return ALU_OR;
      OP_XOR:  return ALU_XOR;
      OP_NOT:  return ALU_NOT;
      OP_SHL:  return ALU_SHL;
      OP_SHR:  return ALU_SHR;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/instr_decoder.sv
// Purely combinational opcode decoder: maps op plus Z/C flags to the
// EXEC-state control bits, branch decision, memory use and flag update.
// Ports: op, zero, carry in; control bits, alu_opcode out.
module instr_decoder
  import cpu_defs::*;
(
  input  logic [3:0] op,
  input  logic       zero,
  input  logic       carry,
  output logic       ra_from_ra,
  output logic       ra_from_rd,
  output logic       rb_from_rb,
  output logic       write_en,
  output logic       write_alu,
  output logic       alu_imm,
  output logic       imm_out,
  output logic       is_mem,
  output logic       mem_we,
  output logic       is_ld,
  output logic       is_halt,
  output logic       is_branch_taken,
  output logic       updates_flags,
  output logic [2:0] alu_opcode
);

  always_comb begin
    ra_from_ra      = 1'b0;
    ra_from_rd      = 1'b0;
    rb_from_rb      = 1'b0;
    write_en        = 1'b0;
    write_alu       = 1'b0;
    alu_imm         = 1'b0;
    imm_out         = 1'b0;
    is_mem          = 1'b0;
    mem_we          = 1'b0;
    is_ld           = 1'b0;
    is_halt         = 1'b0;
    is_branch_taken = 1'b0;
    updates_flags   = 1'b0;
    alu_opcode      = ALU_ADD;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT, OP_SHL, OP_SHR: begin
        ra_from_ra    = 1'b1;
        rb_from_rb    = 1'b1;
        write_en      = 1'b1;
        write_alu     = 1'b1;
        updates_flags = 1'b1;
        alu_opcode    = alu_of_op(op);
      end
      OP_LDI: begin
        // write-back falls through to imm_data when write_alu/is_load are 0
        write_en = 1'b1;
        imm_out  = 1'b1;
      end
      OP_ADDI: begin
        ra_from_rd    = 1'b1;
        alu_imm       = 1'b1;
        imm_out       = 1'b1;
        write_en      = 1'b1;
        write_alu     = 1'b1;
        updates_flags = 1'b1;
      end
      OP_LD: begin
        is_mem = 1'b1;
        is_ld  = 1'b1;
      end
      OP_ST: begin
        ra_from_rd = 1'b1;
        is_mem     = 1'b1;
        mem_we     = 1'b1;
      end
      OP_JMP:  is_branch_taken = 1'b1;
      OP_BZ:   is_branch_taken = zero;
      OP_BC:   is_branch_taken = carry;
      OP_HALT: is_halt = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle fetch/decode/execute sequencer driving all datapath controls.
// Ports: clk/rst; imem addr/data; dmem addr/we; ALU flags in; register
// addresses, write-back selects, ALU opcode, immediate, pc and halted out.
module control_unit
  import cpu_defs::*;
#(
  parameter int              PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic [PC_W-1:0] imem_addr,
  input  logic [15:0]     imem_data,
  output logic [7:0]      dmem_addr,
  output logic            dmem_we,
  input  logic            alu_zero,
  input  logic            alu_carry,
  output logic [3:0]      ra_addr,
  output logic [3:0]      rb_addr,
  output logic [3:0]      write_addr,
  output logic            write_en,
  output logic            write_alu,
  output logic            is_load,
  output logic            alu_imm_flag,
  output logic [2:0]      alu_opcode,
  output logic [7:0]      imm_data,
  output logic [PC_W-1:0] pc,
  output logic            halted
);

  state_t      state;
  logic [15:0] ir;
  logic        flag_z;
  logic        flag_c;

  logic [3:0] op, rd, fa, fb;
  logic [7:0] imm8;
  assign op   = ir[IR_OP_HI:IR_OP_LO];
  assign rd   = ir[IR_RD_HI:IR_RD_LO];
  assign fa   = ir[IR_RA_HI:IR_RA_LO];
  assign fb   = ir[IR_RB_HI:IR_RB_LO];
  assign imm8 = ir[IR_IMM_HI:IR_IMM_LO];

  logic       d_ra_from_ra, d_ra_from_rd, d_rb_from_rb;
  logic       d_write_en, d_write_alu, d_alu_imm, d_imm_out;
  logic       d_is_mem, d_mem_we, d_is_ld, d_is_halt;
  logic       d_taken, d_updates_flags;
  logic [2:0] d_alu_opcode;

  instr_decoder u_dec (
    .op              (op),
    .zero            (flag_z),
    .carry           (flag_c),
    .ra_from_ra      (d_ra_from_ra),
    .ra_from_rd      (d_ra_from_rd),
    .rb_from_rb      (d_rb_from_rb),
    .write_en        (d_write_en),
    .write_alu       (d_write_alu),
    .alu_imm         (d_alu_imm),
    .imm_out         (d_imm_out),
    .is_mem          (d_is_mem),
    .mem_we          (d_mem_we),
    .is_ld           (d_is_ld),
    .is_halt         (d_is_halt),
    .is_branch_taken (d_taken),
    .updates_flags   (d_updates_flags),
    .alu_opcode      (d_alu_opcode)
  );

  assign imem_addr = pc;
  assign halted    = (state == HALT);

  // Controls are a pure function of state and IR; anything not driven in a
  // state stays 0, so FETCH/DECODE/HALT present an idle datapath.
  always_comb begin
    dmem_addr    = '0;
    dmem_we      = 1'b0;
    ra_addr      = '0;
    rb_addr      = '0;
    write_addr   = '0;
    write_en     = 1'b0;
    write_alu    = 1'b0;
    is_load      = 1'b0;
    alu_imm_flag = 1'b0;
    alu_opcode   = '0;
    imm_data     = '0;
    case (state)
      EXEC: begin
        if (d_ra_from_ra)      ra_addr = fa;
        else if (d_ra_from_rd) ra_addr = rd;
        if (d_rb_from_rb)      rb_addr = fb;
        if (d_write_en)        write_addr = rd;
        if (d_imm_out)         imm_data = imm8;
        if (d_is_mem)          dmem_addr = imm8;
        write_en     = d_write_en;
        write_alu    = d_write_alu;
        alu_imm_flag = d_alu_imm;
        alu_opcode   = d_alu_opcode;
        dmem_we      = d_mem_we;
      end
      MEMWB: begin
        // synchronous RAM: address was presented in EXEC, data valid now
        write_en   = 1'b1;
        is_load    = 1'b1;
        write_addr = rd;
        dmem_addr  = imm8;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= FETCH;
      pc     <= RESET_PC;
      ir     <= '0;
      flag_z <= 1'b0;
      flag_c <= 1'b0;
    end else begin
      case (state)
        FETCH: state <= DECODE;
        DECODE: begin
          ir    <= imem_data;
          pc    <= pc + PC_W'(1);
          state <= EXEC;
        end
        EXEC: begin
          // pc already holds the incremented value; a taken branch replaces it
          if (d_taken) pc <= PC_W'(imm8);
          if (d_updates_flags) begin
            flag_z <= alu_zero;
            flag_c <= alu_carry;
          end
          if (d_is_ld)        state <= MEMWB;
          else if (d_is_halt) state <= HALT;
          else                state <= FETCH;
        end
        MEMWB:   state <= FETCH;
        HALT:    state <= HALT;
        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: ROM/RAM/register-file datapath
// around the DUT, an instruction-level reference model that expands each
// instruction into its per-cycle control outputs, and directed programs.
module tb_control_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  imem_addr;
  logic [15:0] imem_data;
  logic [7:0]  dmem_addr;
  logic        dmem_we;
  logic        alu_zero, alu_carry;
  logic [3:0]  ra_addr, rb_addr, write_addr;
  logic        write_en, write_alu, is_load, alu_imm_flag;
  logic [2:0]  alu_opcode;
  logic [7:0]  imm_data;
  logic [7:0]  pc;
  logic        halted;

  always #5 clk = ~clk;

  control_unit #(.PC_W(8), .RESET_PC(8'h00)) dut (
    .clk(clk), .rst(rst),
    .imem_addr(imem_addr), .imem_data(imem_data),
    .dmem_addr(dmem_addr), .dmem_we(dmem_we),
    .alu_zero(alu_zero), .alu_carry(alu_carry),
    .ra_addr(ra_addr), .rb_addr(rb_addr), .write_addr(write_addr),
    .write_en(write_en), .write_alu(write_alu), .is_load(is_load),
    .alu_imm_flag(alu_imm_flag), .alu_opcode(alu_opcode),
    .imm_data(imm_data), .pc(pc), .halted(halted)
  );

  // ALU behaviour of the datapath: {carry, result}
  function automatic logic [8:0] alu_fn(input logic [2:0] f, input logic [7:0] a, input logic [7:0] b);
    case (f)
      3'd0: return {1'b0, a} + {1'b0, b};
      3'd1: return {(a < b), 8'(a - b)};
      3'd2: return {1'b0, a & b};
      3'd3: return {1'b0, a | b};
      3'd4: return {1'b0, a ^ b};
      3'd5: return {1'b0, ~a};
      3'd6: return {a[7], a[6:0], 1'b0};
      default: return {a[0], 1'b0, a[7:1]};
    endcase
  endfunction

  // ---------------- datapath / memories around the DUT ----------------
  logic [15:0] rom [256];
  logic [15:0] rom_q;
  logic [7:0]  dp_regs [16];
  logic [7:0]  dp_ram [256];
  logic [7:0]  ram_q, read_a, opb, wb;
  logic [8:0]  alu_res;

  always @(posedge clk) rom_q <= rom[imem_addr];
  assign imem_data = rom_q;

  always_comb begin
    read_a  = dp_regs[ra_addr];
    opb     = alu_imm_flag ? imm_data : dp_regs[rb_addr];
    alu_res = alu_fn(alu_opcode, read_a, opb);
    wb      = write_alu ? alu_res[7:0] : (is_load ? ram_q : imm_data);
  end
  assign alu_zero  = (alu_res[7:0] == 8'h00);
  assign alu_carry = alu_res[8];

  always @(posedge clk) begin
    if (write_en && !rst) dp_regs[write_addr] <= wb;
    if (dmem_we && !rst)  dp_ram[dmem_addr] <= read_a;
    ram_q <= dp_ram[dmem_addr];
  end

  // ---------------- expected-output vector ----------------
  typedef struct packed {
    logic [7:0] imem;
    logic [7:0] pcv;
    logic [7:0] dmem;
    logic       dwe;
    logic [3:0] ra;
    logic [3:0] rb;
    logic [3:0] wa;
    logic       we;
    logic       walu;
    logic       ld;
    logic       aimm;
    logic [2:0] op;
    logic [7:0] imm;
    logic       hlt;
  } vec_t;

  vec_t dut_v;
  always_comb begin
    dut_v      = '0;
    dut_v.imem = imem_addr;
    dut_v.pcv  = pc;
    dut_v.dmem = dmem_addr;
    dut_v.dwe  = dmem_we;
    dut_v.ra   = ra_addr;
    dut_v.rb   = rb_addr;
    dut_v.wa   = write_addr;
    dut_v.we   = write_en;
    dut_v.walu = write_alu;
    dut_v.ld   = is_load;
    dut_v.aimm = alu_imm_flag;
    dut_v.op   = alu_opcode;
    dut_v.imm  = imm_data;
    dut_v.hlt  = halted;
  end

  // ---------------- instruction-level reference model ----------------
  logic [7:0] m_pc;
  logic [7:0] m_regs [16];
  logic [7:0] m_ram [256];
  logic       m_z, m_c, m_halted;
  vec_t       exp_q[$];

  task automatic model_reset();
    m_pc = 8'h00; m_z = 1'b0; m_c = 1'b0; m_halted = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 16; i++) m_regs[i] = 8'h00;
    for (int i = 0; i < 256; i++) m_ram[i] = dp_ram[i];
  endtask

  // Runs one instruction and queues one expected vector per cycle it takes.
  task automatic model_step();
    vec_t v, w;
    logic [15:0] ins;
    logic [3:0] op, rd, fa, fb;
    logic [7:0] imm, p, pn;
    logic [8:0] r;
    v = '0;
    if (m_halted) begin
      v.imem = m_pc; v.pcv = m_pc; v.hlt = 1'b1;
      exp_q.push_back(v);
      return;
    end
    p = m_pc; pn = p + 8'd1; ins = rom[p];
    op = ins[15:12]; rd = ins[11:8]; fa = ins[7:4]; fb = ins[3:0]; imm = ins[7:0];
    v.imem = p; v.pcv = p;
    exp_q.push_back(v);            // fetch
    exp_q.push_back(v);            // decode
    v.imem = pn; v.pcv = pn;
    m_pc = pn;
    if (op < 4'h8) begin
      v.ra = fa; v.rb = fb; v.wa = rd; v.we = 1'b1; v.walu = 1'b1; v.op = op[2:0];
      r = alu_fn(op[2:0], m_regs[fa], m_regs[fb]);
      m_regs[rd] = r[7:0]; m_z = (r[7:0] == 8'h00); m_c = r[8];
      exp_q.push_back(v);
    end else begin
      case (op)
        4'h8: begin
          v.wa = rd; v.we = 1'b1; v.imm = imm;
          m_regs[rd] = imm;
        end
        4'h9: begin
          v.ra = rd; v.wa = rd; v.aimm = 1'b1; v.walu = 1'b1; v.we = 1'b1; v.imm = imm;
          r = alu_fn(3'd0, m_regs[rd], imm);
          m_regs[rd] = r[7:0]; m_z = (r[7:0] == 8'h00); m_c = r[8];
        end
        4'hA: v.dmem = imm;
        4'hB: begin
          v.ra = rd; v.dmem = imm; v.dwe = 1'b1;
          m_ram[imm] = m_regs[rd];
        end
        4'hC: m_pc = imm;
        4'hD: if (m_z) m_pc = imm;
        4'hE: if (m_c) m_pc = imm;
        default: m_halted = 1'b1;
      endcase
      exp_q.push_back(v);
      if (op == 4'hA) begin
        w = '0; w.imem = pn; w.pcv = pn;
        w.we = 1'b1; w.ld = 1'b1; w.wa = rd; w.dmem = imm;
        m_regs[rd] = m_ram[imm];
        exp_q.push_back(w);
      end
    end
  endtask

  // ---------------- checking ----------------
  int   n_tests = 0;
  int   n_fail  = 0;
  logic chk_en  = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h, expected %0h", nm, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      vec_t e;
      if (exp_q.size() == 0) model_step();
      e = exp_q.pop_front();
      n_tests++;
      if (dut_v !== e) begin
        n_fail++;
        $display("FAIL cycle_vec @%0t: got %h, expected %h", $time, dut_v, e);
      end
    end
  end

  // ---------------- phase helpers ----------------
  task automatic rom_clear();
    for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
  endtask

  task automatic enter_reset();
    rst = 1'b1;
    chk_en = 1'b0;
    repeat (2) @(posedge clk);
    for (int i = 0; i < 16; i++) dp_regs[i] = 8'h00;
    for (int i = 0; i < 256; i++) dp_ram[i] = 8'h00;
  endtask

  task automatic leave_reset(input logic with_model);
    @(posedge clk);
    #2 rst = 1'b0;
    model_reset();
    chk_en = with_model;
  endtask

  task automatic end_phase();
    @(posedge clk);
    #2 chk_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1;

    // ---- Phase A: reset, LDI/ADD, HALT sticky ----
    rom_clear();
    rom[0] = 16'h8105; rom[1] = 16'h8203; rom[2] = 16'h0312; rom[3] = 16'hF000;
    enter_reset();
    @(negedge clk);
    chk("reset_outputs", 64'(dut_v), 64'(0));
    leave_reset(1'b1);
    @(negedge clk);                                   // n=0
    chk("imem_after_rst", 64'(imem_addr), 64'h00);
    repeat (3) @(negedge clk);                        // n=3
    chk("imem_second", 64'(imem_addr), 64'h01);
    repeat (5) @(negedge clk);                        // n=8, ADD EXEC
    chk("add_ra", 64'(ra_addr), 64'd1);
    chk("add_rb", 64'(rb_addr), 64'd2);
    chk("add_wa", 64'(write_addr), 64'd3);
    chk("add_we", 64'({write_en, write_alu}), 64'b11);
    @(negedge clk);                                   // n=9
    chk("add_we_one_cycle", 64'(write_en), 64'd0);
    repeat (26) @(negedge clk);                       // well past HALT
    chk("halted", 64'(halted), 64'd1);
    chk("halt_strobes", 64'({write_en, dmem_we}), 64'd0);
    chk("halt_pc", 64'(pc), 64'h04);
    chk("dp_r3", 64'(dp_regs[3]), 64'h08);
    chk("model_r3", 64'(m_regs[3]), 64'h08);
    end_phase();

    // ---- Phase B: LD / ST ----
    rom_clear();
    rom[0] = 16'hAD40; rom[1] = 16'hBD41; rom[2] = 16'hF000;
    enter_reset();
    dp_ram[8'h40] = 8'h6C;
    leave_reset(1'b1);
    @(negedge clk);                                   // n=0
    repeat (3) @(negedge clk);                        // n=3, MEMWB
    chk("ld_memwb", 64'({is_load, write_en, write_addr, dmem_addr}), 64'({1'b1, 1'b1, 4'd13, 8'h40}));
    @(negedge clk);                                   // n=4
    chk("ld_4cycles", 64'(imem_addr), 64'h01);
    repeat (2) @(negedge clk);                        // n=6, ST EXEC
    chk("st_exec", 64'({dmem_we, dmem_addr, read_a}), 64'({1'b1, 8'h41, 8'h6C}));
    repeat (9) @(negedge clk);
    chk("dp_ram41", 64'(dp_ram[8'h41]), 64'h6C);
    chk("dp_r13", 64'(dp_regs[13]), 64'h6C);
    end_phase();

    // ---- Phase C: flags and branches ----
    rom_clear();
    rom[8'h00] = 16'h8101; rom[8'h01] = 16'h1111; rom[8'h02] = 16'hD020;
    rom[8'h20] = 16'h82FF; rom[8'h21] = 16'h9201; rom[8'h22] = 16'hE030;
    rom[8'h30] = 16'h8501; rom[8'h31] = 16'h0655; rom[8'h32] = 16'hD050;
    rom[8'h33] = 16'hF000;
    enter_reset();
    leave_reset(1'b1);
    @(negedge clk);                                   // n=0
    repeat (9) @(negedge clk);                        // n=9
    chk("bz_taken", 64'(imem_addr), 64'h20);
    repeat (9) @(negedge clk);                        // n=18
    chk("bc_taken", 64'(imem_addr), 64'h30);
    repeat (9) @(negedge clk);                        // n=27
    chk("bz_not_taken", 64'(imem_addr), 64'h33);
    repeat (13) @(negedge clk);
    chk("branch_final_pc", 64'(pc), 64'h34);
    chk("model_final_pc", 64'(m_pc), 64'h34);
    chk("dp_r2", 64'(dp_regs[2]), 64'h00);
    chk("dp_r6", 64'(dp_regs[6]), 64'h02);
    end_phase();

    // ---- Phase D: pc wrap ----
    rom_clear();
    rom[8'h00] = 16'hC0FF; rom[8'hFF] = 16'h84AA;
    enter_reset();
    leave_reset(1'b1);
    @(negedge clk);                                   // n=0
    repeat (3) @(negedge clk);                        // n=3
    chk("jmp_ff", 64'(imem_addr), 64'hFF);
    repeat (3) @(negedge clk);                        // n=6
    chk("wrap_00", 64'(imem_addr), 64'h00);
    repeat (6) @(negedge clk);
    chk("dp_r4", 64'(dp_regs[4]), 64'hAA);
    end_phase();

    // ---- Phase E: reset during ADD EXEC ----
    rom_clear();
    rom[0] = 16'h8105; rom[1] = 16'h8203; rom[2] = 16'h0312; rom[3] = 16'hF000;
    enter_reset();
    leave_reset(1'b0);
    @(negedge clk);                                   // n=0
    repeat (8) @(negedge clk);                        // n=8, ADD EXEC
    chk("add_exec_pre_rst", 64'(write_en), 64'd1);
    #1 rst = 1'b1;
    #1;
    chk("rst_kills_we", 64'(write_en), 64'd0);
    chk("rst_pc", 64'(pc), 64'h00);
    @(posedge clk);
    #1;
    chk("no_partial_write", 64'(dp_regs[3]), 64'h00);
    chk("r1_before_rst", 64'(dp_regs[1]), 64'h05);
    leave_reset(1'b1);
    @(negedge clk);
    chk("restart_pc", 64'(imem_addr), 64'h00);
    repeat (15) @(negedge clk);
    chk("restart_r3", 64'(dp_regs[3]), 64'h08);
    end_phase();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
Multi-cycle fetch/decode/execute sequencer for the 8-bit core. It sits directly upstream of the datapath and drives every datapath control input: register addresses, write enables, ALU opcode, immediate, load select and immediate select. It owns the program counter, the instruction register and the zero/carry flag register, and the instruction-memory and data-memory address/strobe ports.

Parameters:
PC_W, 8, program counter and instruction-memory address width
RESET_PC, 8'h00, PC value loaded on reset

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-high reset
imem_addr  out  PC_W  instruction address (= pc)
imem_data  in  16  instruction word; synchronous ROM, valid one cycle after imem_addr
dmem_addr  out  8  data RAM address
dmem_we  out  1  data RAM write strobe; write data is datapath read_a, wired at top level
alu_zero  in  1  datapath ALU zero flag
alu_carry  in  1  datapath ALU carry flag
ra_addr, rb_addr, write_addr  out  4 each  datapath register addresses
write_en  out  1  register-file write enable
write_alu  out  1  write-back source = ALU
is_load  out  1  write-back source = ram_data (only when write_alu=0)
alu_imm_flag  out  1  ALU B operand = imm_data
alu_opcode  out  3  ADD 0, SUB 1, AND 2, OR 3, XOR 4, NOT 5, SHL 6, SHR 7
imm_data  out  8  immediate = IR[7:0]
pc  out  PC_W  current program counter
halted  out  1  high once HALT has executed

Behaviour:
- Instruction: IR[15:12] op, IR[11:8] rd, IR[7:4] ra, IR[3:0] rb, IR[7:0] imm8.
- Ops:
  - 0x0-0x7: rd <= ra OP rb, with alu_opcode = op[2:0].
  - 0x8 LDI: rd <= imm8.
  - 0x9 ADDI: rd <= rd + imm8.
  - 0xA LD: rd <= RAM[imm8].
  - 0xB ST: RAM[imm8] <= rd.
  - 0xC JMP imm8.
  - 0xD BZ imm8: branch if Z.
  - 0xE BC imm8: branch if C.
  - 0xF HALT.
- States:
  - FETCH: drive imem_addr = pc; go to DECODE.
  - DECODE: IR <= imem_data; pc <= pc+1 (wraps FF->00); go to EXEC.
  - EXEC: drive the controls below. LD goes to MEMWB; HALT goes to HALT; all other ops go to FETCH.
  - MEMWB: write_en=1, is_load=1, write_addr=rd, dmem_addr=imm8; go to FETCH.
  - HALT: all strobes 0, halted=1. Stays here until rst.
- EXEC controls:
  - ALU ops: ra_addr=ra, rb_addr=rb, write_addr=rd, write_alu=1, write_en=1.
  - LDI: write_en=1, write_alu=0, is_load=0.
  - ADDI: ra_addr=rd, alu_imm_flag=1, alu_opcode=ADD, write_alu=1, write_en=1.
  - LD: dmem_addr=imm8, no write yet.
  - ST: ra_addr=rd, dmem_addr=imm8, dmem_we=1.
  - JMP/BZ/BC: pc <= imm8 if taken. The taken overwrite takes priority over the DECODE increment.
- Write-back select is fixed: write_alu=1 selects alu_out; else is_load=1 selects ram_data; else imm_data.
- Flags Z,C latch alu_zero/alu_carry at the end of EXEC for ops 0x0-0x7 and 0x9 only. LD, LDI, ST and branches leave them unchanged.
- Latency: 3 cycles per instruction, except LD at 4 cycles. HALT takes 3 cycles, then it is sticky.
- Strobes: write_en and dmem_we are high for exactly one cycle per instruction and are 0 in FETCH/DECODE. In any state, every control output not listed for that state is 0.
- rd=0 writes are still issued; the datapath discards them. Z/C still update.
- Reset values: state=FETCH, pc=RESET_PC, IR=0, Z=C=0, halted=0. All control outputs are 0 and imem_addr=RESET_PC.
- rst mid-instruction aborts the instruction; no partial write occurs after rst rises.
- Outputs are decoded combinationally from state and IR; pc, IR, flags and state are registered.

Decomposition:
- Shared package/header `cpu_defs` holds:
  - ALU opcode constants (ADD..SHR, identical to the datapath's);
  - the instruction opcode constants 0x0-0xF;
  - the state encodings FETCH/DECODE/EXEC/MEMWB/HALT;
  - the IR field bit positions.
- One natural sub-module: `instr_decoder`, purely combinational. It maps op plus the flags to control bits plus is_branch_taken, is_mem and updates_flags.
- The FSM, pc, IR and flags stay in control_unit.

Test Plan:
- Reset: hold rst for 2 cycles with ROM[0]=8'h? → all outputs 0 and pc=00. After release: imem_addr=00, then 01 after 3 cycles.
- LDI/ADD: LDI R1,05; LDI R2,03; ADD R3,R1,R2 → ADD EXEC shows ra=1, rb=2, write_addr=3, write_alu=1, write_en=1 for one cycle; the datapath model gives R3=08.
- LD/ST: RAM[0x40]=6C; LD R13,40; ST R13,41 → LD takes 4 cycles with is_load=1 in MEMWB; then dmem_we=1 with dmem_addr=41 and read_a=6C.
- Flags/branch: LDI R1,01; SUB R1,R1,R1 (Z=1); BZ 20 → pc=20 next FETCH. LDI R2,FF; ADDI R2,01 (C=1, Z=1); BC 30 → pc=30. A not-taken BZ with Z=0 → pc = branch address + 1.
- Wrap: JMP FF; ROM[FF]=LDI R4,AA → next fetch address is 00.
- HALT: HALT, then 20 idle cycles → halted=1, write_en=dmem_we=0, pc frozen. Assert rst mid-EXEC of an ADD → no write_en pulse, and restart at RESET_PC.
